signal_debouncer: RTL

//  Conditions a raw, asynchronous, bouncy 1-bit input, e.g. a push-button or external strobe.

---
 rtl/signal_debouncer_if.sv | 21 ++
 rtl/signal_debouncer.sv | 87 ++++++++
 2 files changed

// File: rtl/signal_debouncer_if.sv
// Debouncer signal bundle: raw input toward the conditioner, clean level and status back.
interface signal_debouncer_if;
    logic signal_raw;
    logic signal_out;
    logic changed;
    logic busy;

    modport master (
        output signal_raw,
        input  signal_out,
        input  changed,
        input  busy
    );

    modport slave (
        input  signal_raw,
        output signal_out,
        output changed,
        output busy
    );
endinterface

// File: rtl/signal_debouncer.sv
// Synchronizes a bouncy raw input and accepts a new level only after it holds for
// DEBOUNCE_CYCLES consecutive clocks; all outputs are registered.
module signal_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    signal_debouncer_if.slave  dbif
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {STABLE, CHECK} state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   out_q, out_n;
    logic                   changed_q, changed_n;
    logic                   busy_q;

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], dbif.signal_raw};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STABLE;
            cnt       <= '0;
            out_q     <= RESET_LEVEL;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            out_q     <= out_n;
            changed_q <= changed_n;
            busy_q    <= (state_n == CHECK);
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        out_n     = out_q;
        changed_n = 1'b0;
        case (state)
            STABLE: begin
                cnt_n = '0;
                if (sync_q != out_q) begin
                    state_n = CHECK;
                    cnt_n   = CNT_W'(1);
                end
            end
            CHECK: begin
                if (sync_q == out_q) begin
                    // Candidate fell back before qualifying: drop it silently.
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_n   = STABLE;
                    cnt_n     = '0;
                    out_n     = ~out_q;
                    changed_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = STABLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign dbif.signal_out = out_q;
    assign dbif.changed    = changed_q;
    assign dbif.busy       = busy_q;
endmodule
